// File: rtl/spmv_mem_pkg.sv
// Shared widths and request/response record types for the SpMV memory port.
package spmv_mem_pkg;

    localparam int ADDR_W  = 48;
    localparam int DATA_W  = 64;
    localparam int TAG_W   = 3;
    localparam int RDCTL_W = 32;

    // Request as captured from the PE: store flag, byte address, store data or load tag.
    typedef struct packed {
        logic              is_st;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mem_req_t;

    // Load return: original tag plus read data.
    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] data;
    } mem_rsp_t;

    // Load rdctl sent to the MC carries only the tag; everything above it is zero.
    function automatic logic [DATA_W-1:0] rdctl_word(input logic [DATA_W-1:0] d);
        return {{(DATA_W-TAG_W){1'b0}}, d[TAG_W-1:0]};
    endfunction

endpackage

// File: rtl/spmv_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when empty are ignored.
module spmv_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign dout    = mem[rd_ptr];

    // Storage array; no reset needed since reads are gated by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/spmv_mem_port.sv
// Adapter between spmv_pe's memory port and one MC port: request buffering,
// credit-metered load issue, response buffering and drain/idle reporting.
module spmv_mem_port
    import spmv_mem_pkg::*;
#(
    parameter int REQ_DEPTH    = 8,
    parameter int RSP_DEPTH    = 8,
    parameter int STALL_MARGIN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_mem_ld,
    input  logic               req_mem_st,
    input  logic [ADDR_W-1:0]  req_mem_addr,
    input  logic [DATA_W-1:0]  req_mem_d_or_tag,
    output logic               req_mem_stall,
    output logic               rsp_mem_push,
    output logic [TAG_W-1:0]   rsp_mem_tag,
    output logic [DATA_W-1:0]  rsp_mem_q,
    input  logic               rsp_mem_stall,
    output logic               mc_req_ld,
    output logic               mc_req_st,
    output logic [ADDR_W-1:0]  mc_req_vadr,
    output logic [DATA_W-1:0]  mc_req_wrd_rdctl,
    input  logic               mc_rd_rq_stall,
    input  logic               mc_wr_rq_stall,
    input  logic               mc_rsp_push,
    input  logic [RDCTL_W-1:0] mc_rsp_rdctl,
    input  logic [DATA_W-1:0]  mc_rsp_data,
    output logic               mc_rsp_stall,
    output logic               idle,
    output logic               err
);

    localparam int RQ_CW = $clog2(REQ_DEPTH) + 1;
    localparam int CR_W  = $clog2(RSP_DEPTH) + 1;
    localparam logic [RQ_CW-1:0] STALL_LVL = RQ_CW'(REQ_DEPTH - STALL_MARGIN);
    localparam logic [CR_W-1:0]  CRED_MAX  = CR_W'(RSP_DEPTH);

    mem_req_t          req_in, req_head;
    mem_rsp_t          rsp_in, rsp_head;
    logic [RQ_CW-1:0]  req_count;
    logic [CR_W-1:0]   rsp_count;
    logic              req_full, req_empty, rsp_full, rsp_empty;
    logic [CR_W-1:0]   credits, credits_nxt;
    logic [CR_W:0]     claimed;
    logic [RQ_CW-1:0]  req_left;
    logic              req_one, req_push, req_bad;
    logic              issue_ld, issue_st, issue;
    logic              rsp_ok, rsp_push, rsp_bad, rsp_pop;
    logic              unused_rdctl;

    assign unused_rdctl = ^mc_rsp_rdctl[RDCTL_W-1:TAG_W];

    // Request capture: exactly one strobe, and room in the FIFO.
    assign req_one  = req_mem_ld ^ req_mem_st;
    assign req_push = req_one && !req_full;
    assign req_bad  = (req_mem_ld && req_mem_st) || (req_one && req_full);
    assign req_in   = '{is_st: req_mem_st, addr: req_mem_addr, data: req_mem_d_or_tag};

    assign req_mem_stall = (req_count >= STALL_LVL);
    assign mc_rsp_stall  = 1'b0;

    spmv_sync_fifo #(.WIDTH($bits(mem_req_t)), .DEPTH(REQ_DEPTH)) u_req_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (req_push),
        .din   (req_in),
        .pop   (issue),
        .dout  (req_head),
        .count (req_count),
        .full  (req_full),
        .empty (req_empty)
    );

    // In-order issue: the head alone decides; a starved load holds back later stores.
    assign issue_ld = !req_empty && !req_head.is_st && !mc_rd_rq_stall && (credits != '0);
    assign issue_st = !req_empty &&  req_head.is_st && !mc_wr_rq_stall;
    assign issue    = issue_ld || issue_st;

    // A credit is held from load issue until its data leaves toward the PE, so
    // credits + rsp_count < RSP_DEPTH means some load is still out at the MC.
    // This rejects both unsolicited responses and any push into a full FIFO.
    assign claimed  = {1'b0, credits} + {1'b0, rsp_count};
    assign rsp_ok   = (claimed < {1'b0, CRED_MAX});
    assign rsp_push = mc_rsp_push && rsp_ok;
    assign rsp_bad  = mc_rsp_push && !rsp_ok;
    assign rsp_in   = '{tag: mc_rsp_rdctl[TAG_W-1:0], data: mc_rsp_data};
    assign rsp_pop  = !rsp_empty && !rsp_mem_stall;

    spmv_sync_fifo #(.WIDTH($bits(mem_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rsp_push),
        .din   (rsp_in),
        .pop   (rsp_pop),
        .dout  (rsp_head),
        .count (rsp_count),
        .full  (rsp_full),
        .empty (rsp_empty)
    );

    // Next credit value: load issue takes one, a response pop returns one.
    always_comb begin
        credits_nxt = credits;
        case ({issue_ld, rsp_pop})
            2'b10:   credits_nxt = credits - 1'b1;
            2'b01:   credits_nxt = credits + 1'b1;
            default: ;
        endcase
    end

    assign req_left = req_count - RQ_CW'(issue);

    // Credit counter, sticky error and idle (all credits home implies no
    // outstanding loads and an empty response FIFO).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            credits <= CRED_MAX;
            err     <= 1'b0;
            idle    <= 1'b1;
        end else begin
            credits <= credits_nxt;
            if (req_bad || rsp_bad) err <= 1'b1;
            idle <= !req_push && (req_left == '0) && (credits_nxt == CRED_MAX);
        end
    end

    // Registered MC request; strobes last one cycle per issued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_req_ld        <= 1'b0;
            mc_req_st        <= 1'b0;
            mc_req_vadr      <= '0;
            mc_req_wrd_rdctl <= '0;
        end else begin
            mc_req_ld <= issue_ld;
            mc_req_st <= issue_st;
            if (issue) begin
                mc_req_vadr      <= req_head.addr;
                mc_req_wrd_rdctl <= req_head.is_st ? req_head.data : rdctl_word(req_head.data);
            end
        end
    end

    // Registered return to the PE; one push per popped entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_mem_push <= 1'b0;
            rsp_mem_tag  <= '0;
            rsp_mem_q    <= '0;
        end else begin
            rsp_mem_push <= rsp_pop;
            if (rsp_pop) begin
                rsp_mem_tag <= rsp_head.tag;
                rsp_mem_q   <= rsp_head.data;
            end
        end
    end

endmodule

// File: tb/tb_spmv_mem_port.sv
// Self-checking bench for spmv_mem_port: directed scenarios plus randomized
// traffic against a queue-based model of ordering and credit rules.
module tb_spmv_mem_port;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_mem_ld = 0, req_mem_st = 0;
    logic [47:0] req_mem_addr = '0;
    logic [63:0] req_mem_d_or_tag = '0;
    logic        req_mem_stall;
    logic        rsp_mem_push;
    logic [2:0]  rsp_mem_tag;
    logic [63:0] rsp_mem_q;
    logic        rsp_mem_stall = 0;
    logic        mc_req_ld, mc_req_st;
    logic [47:0] mc_req_vadr;
    logic [63:0] mc_req_wrd_rdctl;
    logic        mc_rd_rq_stall = 0, mc_wr_rq_stall = 0;
    logic        mc_rsp_push = 0;
    logic [31:0] mc_rsp_rdctl = '0;
    logic [63:0] mc_rsp_data = '0;
    logic        mc_rsp_stall;
    logic        idle, err;

    spmv_mem_port dut (
        .clk(clk), .rst_n(rst_n),
        .req_mem_ld(req_mem_ld), .req_mem_st(req_mem_st),
        .req_mem_addr(req_mem_addr), .req_mem_d_or_tag(req_mem_d_or_tag),
        .req_mem_stall(req_mem_stall),
        .rsp_mem_push(rsp_mem_push), .rsp_mem_tag(rsp_mem_tag), .rsp_mem_q(rsp_mem_q),
        .rsp_mem_stall(rsp_mem_stall),
        .mc_req_ld(mc_req_ld), .mc_req_st(mc_req_st),
        .mc_req_vadr(mc_req_vadr), .mc_req_wrd_rdctl(mc_req_wrd_rdctl),
        .mc_rd_rq_stall(mc_rd_rq_stall), .mc_wr_rq_stall(mc_wr_rq_stall),
        .mc_rsp_push(mc_rsp_push), .mc_rsp_rdctl(mc_rsp_rdctl), .mc_rsp_data(mc_rsp_data),
        .mc_rsp_stall(mc_rsp_stall), .idle(idle), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; logic is_st; logic [47:0] a; logic [63:0] w; } req_ev_t;
    typedef struct { int cyc; logic [2:0] tag; logic [63:0] q; } rsp_ev_t;

    req_ev_t    req_log[$];
    req_ev_t    sent[$];
    rsp_ev_t    rsp_log[$];
    rsp_ev_t    exp_rsp[$];
    logic [2:0] pend[$];
    int cyc_n = 0, ld_cnt = 0, max_out = 0;
    int n_chk = 0, n_bad = 0;

    // Advance one cycle and record what the DUT presented after the posedge.
    task automatic tick();
        @(negedge clk);
        cyc_n++;
        if (mc_req_ld || mc_req_st)
            req_log.push_back('{cyc_n, mc_req_st, mc_req_vadr, mc_req_wrd_rdctl});
        if (mc_req_ld) begin
            ld_cnt++;
            pend.push_back(mc_req_wrd_rdctl[2:0]);
        end
        if (rsp_mem_push) rsp_log.push_back('{cyc_n, rsp_mem_tag, rsp_mem_q});
        if (ld_cnt - rsp_log.size() > max_out) max_out = ld_cnt - rsp_log.size();
    endtask

    task automatic do_reset();
        req_mem_ld = 0; req_mem_st = 0; rsp_mem_stall = 0;
        mc_rd_rq_stall = 0; mc_wr_rq_stall = 0; mc_rsp_push = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
        tick();
        req_log.delete(); sent.delete(); rsp_log.delete(); exp_rsp.delete(); pend.delete();
        ld_cnt = 0; max_out = 0;
    endtask

    task automatic mc_respond(input logic [2:0] tag, input logic [63:0] d);
        mc_rsp_push = 1; mc_rsp_rdctl = {29'h0, tag}; mc_rsp_data = d;
        exp_rsp.push_back('{0, tag, d});
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if ({mc_req_ld, mc_req_st, rsp_mem_push, req_mem_stall, mc_rsp_stall, err} !== 6'b0) begin
            n_bad++; $display("FAIL reset_outs got=%b want=000000", {mc_req_ld, mc_req_st, rsp_mem_push, req_mem_stall, mc_rsp_stall, err}); end
        n_chk++; if (idle !== 1'b1) begin n_bad++; $display("FAIL reset_idle got=%b want=1", idle); end
        n_chk++; if (dut.credits !== 4'd8) begin n_bad++; $display("FAIL reset_credits got=%0d want=8", dut.credits); end
    endtask

    task automatic test_single_load();
        logic [63:0] d;
        d = 64'h3FF0000000000000;
        do_reset();
        req_mem_ld = 1; req_mem_addr = 48'h1000; req_mem_d_or_tag = 64'd5;
        tick();
        req_mem_ld = 0;
        n_chk++; if (mc_req_ld !== 1'b0 || idle !== 1'b0) begin
            n_bad++; $display("FAIL single_accept ld=%b idle=%b want ld=0 idle=0", mc_req_ld, idle); end
        tick();
        n_chk++; if (mc_req_ld !== 1'b1 || mc_req_vadr !== 48'h1000 || mc_req_wrd_rdctl !== 64'd5) begin
            n_bad++; $display("FAIL single_issue ld=%b vadr=%h rdctl=%h want 1/1000/5", mc_req_ld, mc_req_vadr, mc_req_wrd_rdctl); end
        tick();
        n_chk++; if (mc_req_ld !== 1'b0) begin n_bad++; $display("FAIL single_pulse ld=%b want 0", mc_req_ld); end
        mc_respond(3'd5, d);
        tick();
        mc_rsp_push = 0;
        n_chk++; if (rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL single_rsp_early push=%b want 0", rsp_mem_push); end
        tick();
        n_chk++; if (rsp_mem_push !== 1'b1 || rsp_mem_tag !== 3'd5 || rsp_mem_q !== d || idle !== 1'b1) begin
            n_bad++; $display("FAIL single_rsp push=%b tag=%0d q=%h idle=%b want 1/5/%h/1", rsp_mem_push, rsp_mem_tag, rsp_mem_q, idle, d); end
        tick();
        n_chk++; if (rsp_mem_push !== 1'b0) begin n_bad++; $display("FAIL single_rsp_once push=%b want 0", rsp_mem_push); end
    endtask

    task automatic test_credit_exhaustion();
        int r;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            req_mem_ld = 1; req_mem_addr = 48'h2000 + 48'(i * 8); req_mem_d_or_tag = 64'(i);
            tick();
        end
        req_mem_ld = 0;
        repeat (15) tick();
        n_chk++; if (ld_cnt !== 8) begin n_bad++; $display("FAIL credit_limit loads=%0d want 8", ld_cnt); end
        mc_respond(3'd0, {$urandom, $urandom});
        tick();
        r = cyc_n;
        mc_rsp_push = 0;
        repeat (4) tick();
        n_chk++; if (rsp_log.size() !== 1 || ld_cnt !== 9) begin
            n_bad++; $display("FAIL credit_refill rsps=%0d loads=%0d want 1/9", rsp_log.size(), ld_cnt);
        end else if (rsp_log[0].cyc !== r + 1 || req_log[8].cyc !== r + 2) begin
            n_bad++; $display("FAIL credit_timing pop_cyc=%0d issue_cyc=%0d want %0d/%0d", rsp_log[0].cyc, req_log[8].cyc, r + 1, r + 2);
        end
        for (int k = 1; k < 10; k++) begin
            mc_respond(3'(k), {$urandom, $urandom});
            tick();
        end
        mc_rsp_push = 0;
        repeat (6) tick();
        n_chk++; if (ld_cnt !== 10 || rsp_log.size() !== 10 || idle !== 1'b1 || err !== 1'b0) begin
            n_bad++; $display("FAIL credit_drain loads=%0d rsps=%0d idle=%b err=%b want 10/10/1/0", ld_cnt, rsp_log.size(), idle, err);
        end else begin
            for (int i = 0; i < 10; i++) begin
                n_chk++; if (rsp_log[i].tag !== exp_rsp[i].tag || rsp_log[i].q !== exp_rsp[i].q || req_log[i].a !== 48'h2000 + 48'(i * 8)) begin
                    n_bad++; $display("FAIL credit_data[%0d] tag=%0d q=%h a=%h want %0d/%h/%h", i, rsp_log[i].tag, rsp_log[i].q, req_log[i].a, exp_rsp[i].tag, exp_rsp[i].q, 48'h2000 + 48'(i * 8)); end
            end
        end
    endtask

    task automatic test_ooo_backpressure();
        logic [2:0] order [3];
        int c;
        order[0] = 3'd2; order[1] = 3'd0; order[2] = 3'd1;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_mem_ld = 1; req_mem_addr = 48'h3000 + 48'(i); req_mem_d_or_tag = 64'(i);
            tick();
        end
        req_mem_ld = 0;
        repeat (3) tick();
        n_chk++; if (ld_cnt !== 3) begin n_bad++; $display("FAIL ooo_issue loads=%0d want 3", ld_cnt); end
        rsp_mem_stall = 1;
        for (int i = 0; i < 3; i++) begin
            mc_respond(order[i], {$urandom, $urandom});
            tick();
        end
        mc_rsp_push = 0;
        tick(); tick();
        n_chk++; if (rsp_log.size() !== 0) begin n_bad++; $display("FAIL ooo_stalled pushes=%0d want 0", rsp_log.size()); end
        rsp_mem_stall = 0;
        tick();
        c = cyc_n;
        repeat (3) tick();
        n_chk++; if (rsp_log.size() !== 3) begin
            n_bad++; $display("FAIL ooo_count pushes=%0d want 3", rsp_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_chk++; if (rsp_log[i].tag !== order[i] || rsp_log[i].cyc !== c + i || rsp_log[i].q !== exp_rsp[i].q) begin
                    n_bad++; $display("FAIL ooo_rsp[%0d] tag=%0d cyc=%0d want %0d/%0d", i, rsp_log[i].tag, rsp_log[i].cyc, order[i], c + i); end
            end
        end
    endtask

    task automatic test_stall_margin();
        logic [63:0] sd [9];
        do_reset();
        mc_wr_rq_stall = 1;
        for (int k = 1; k <= 8; k++) begin
            sd[k] = {$urandom, $urandom};
            req_mem_st = 1; req_mem_addr = 48'h4000 + 48'(k); req_mem_d_or_tag = sd[k];
            tick();
            n_chk++; if (req_mem_stall !== (k >= 6)) begin
                n_bad++; $display("FAIL margin_stall after %0d got=%b want=%b", k, req_mem_stall, (k >= 6)); end
        end
        n_chk++; if (err !== 1'b0) begin n_bad++; $display("FAIL margin_accept err=%b want 0", err); end
        req_mem_d_or_tag = 64'hDEAD;
        tick();
        req_mem_st = 0;
        n_chk++; if (err !== 1'b1) begin n_bad++; $display("FAIL margin_overflow err=%b want 1", err); end
        mc_wr_rq_stall = 0;
        repeat (12) tick();
        n_chk++; if (req_log.size() !== 8) begin
            n_bad++; $display("FAIL margin_drain stores=%0d want 8", req_log.size());
        end else begin
            for (int k = 1; k <= 8; k++) begin
                n_chk++; if (req_log[k-1].is_st !== 1'b1 || req_log[k-1].w !== sd[k] || req_log[k-1].a !== 48'h4000 + 48'(k)) begin
                    n_bad++; $display("FAIL margin_store[%0d] w=%h a=%h want %h/%h", k, req_log[k-1].w, req_log[k-1].a, sd[k], 48'h4000 + 48'(k)); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_mem_ld = 1; req_mem_addr = 48'h5000 + 48'(i); req_mem_d_or_tag = 64'(i);
            tick();
        end
        req_mem_ld = 0;
        repeat (3) tick();
        n_chk++; if (ld_cnt !== 3) begin n_bad++; $display("FAIL midrst_issue loads=%0d want 3", ld_cnt); end
        rst_n = 0;
        #1;
        n_chk++; if (dut.credits !== 4'd8 || idle !== 1'b1) begin
            n_bad++; $display("FAIL midrst_async credits=%0d idle=%b want 8/1", dut.credits, idle); end
        tick();
        rst_n = 1;
        tick();
        n_chk++; if (err !== 1'b0) begin n_bad++; $display("FAIL midrst_err_clear err=%b want 0", err); end
        for (int i = 0; i < 3; i++) begin
            mc_rsp_push = 1; mc_rsp_rdctl = 32'(i); mc_rsp_data = {$urandom, $urandom};
            tick();
        end
        mc_rsp_push = 0;
        repeat (4) tick();
        n_chk++; if (rsp_log.size() !== 0 || err !== 1'b1 || dut.credits !== 4'd8) begin
            n_bad++; $display("FAIL midrst_stale pushes=%0d err=%b credits=%0d want 0/1/8", rsp_log.size(), err, dut.credits); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        req_mem_ld = 1; req_mem_st = 1; req_mem_addr = 48'h6000; req_mem_d_or_tag = 64'h1;
        tick();
        req_mem_ld = 0; req_mem_st = 0;
        n_chk++; if (err !== 1'b1) begin n_bad++; $display("FAIL both_err err=%b want 1", err); end
        repeat (3) tick();
        n_chk++; if (req_log.size() !== 0 || idle !== 1'b1) begin
            n_bad++; $display("FAIL both_dropped issued=%0d idle=%b want 0/1", req_log.size(), idle); end
    endtask

    // Random PE/MC traffic: issue order must equal send order, returns must
    // follow MC push order, and in-flight loads never exceed the credit limit.
    task automatic test_random();
        logic [63:0] d;
        logic [47:0] a;
        int idx, n;
        do_reset();
        for (int cy = 0; cy < 1500; cy++) begin
            req_mem_ld = 0; req_mem_st = 0; mc_rsp_push = 0;
            if (cy < 1200 && !req_mem_stall && ($urandom_range(0, 3) != 0)) begin
                d = {$urandom, $urandom};
                a = 48'({$urandom, $urandom});
                req_mem_addr = a; req_mem_d_or_tag = d;
                if ($urandom_range(0, 2) == 0) begin
                    req_mem_st = 1; sent.push_back('{0, 1'b1, a, d});
                end else begin
                    req_mem_ld = 1; sent.push_back('{0, 1'b0, a, {61'h0, d[2:0]}});
                end
            end
            mc_rd_rq_stall = (cy < 1200) && ($urandom_range(0, 4) == 0);
            mc_wr_rq_stall = (cy < 1200) && ($urandom_range(0, 4) == 0);
            rsp_mem_stall  = (cy < 1200) && ($urandom_range(0, 3) == 0);
            if (pend.size() > 0 && ($urandom_range(0, 2) != 0)) begin
                idx = $urandom_range(0, pend.size() - 1);
                mc_respond(pend[idx], {$urandom, $urandom});
                pend.delete(idx);
            end
            tick();
            if (cy >= 1200 && pend.size() == 0 && idle && req_log.size() == sent.size()) break;
        end
        mc_rsp_push = 0; rsp_mem_stall = 0; mc_rd_rq_stall = 0; mc_wr_rq_stall = 0;
        repeat (3) tick();
        n_chk++; if (idle !== 1'b1 || err !== 1'b0 || max_out > 8) begin
            n_bad++; $display("FAIL rand_end idle=%b err=%b max_inflight=%0d want 1/0/<=8", idle, err, max_out); end
        n_chk++; if (req_log.size() !== sent.size() || rsp_log.size() !== exp_rsp.size()) begin
            n_bad++; $display("FAIL rand_counts reqs=%0d/%0d rsps=%0d/%0d", req_log.size(), sent.size(), rsp_log.size(), exp_rsp.size()); end
        n = (req_log.size() < sent.size()) ? req_log.size() : sent.size();
        for (int i = 0; i < n; i++) begin
            n_chk++; if (req_log[i].is_st !== sent[i].is_st || req_log[i].a !== sent[i].a || req_log[i].w !== sent[i].w) begin
                n_bad++; $display("FAIL rand_req[%0d] st=%b a=%h w=%h want %b/%h/%h", i, req_log[i].is_st, req_log[i].a, req_log[i].w, sent[i].is_st, sent[i].a, sent[i].w); end
        end
        n = (rsp_log.size() < exp_rsp.size()) ? rsp_log.size() : exp_rsp.size();
        for (int i = 0; i < n; i++) begin
            n_chk++; if (rsp_log[i].tag !== exp_rsp[i].tag || rsp_log[i].q !== exp_rsp[i].q) begin
                n_bad++; $display("FAIL rand_rsp[%0d] tag=%0d q=%h want %0d/%h", i, rsp_log[i].tag, rsp_log[i].q, exp_rsp[i].tag, exp_rsp[i].q); end
        end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_credit_exhaustion();
        test_ooo_backpressure();
        test_stall_margin();
        test_reset_midflight();
        test_simultaneous();
        test_random();
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
